rf_writeback_arbiter: RTL and testbench

// - Write-side initiator for the dual-port (A/B) 32x32 CPU register file of the dual-issue RV32 core.
// - Accepts retiring instruction pairs from the two execution lanes and buffers them in an in-order pair FIFO.
// - Drives the register file write ports (a_we/a_rd/a_wd, b_we/b_rd/b_wd) one pair per cycle.
// - Guarantees the write ports never see a WAW collision or an x0 write; exports a pending-write mask for the issue stage's RAW stall.

---
 rtl/rf_writeback_arbiter.sv | 177 +++++++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
// Buffers retiring instruction pairs from the two execution lanes in an
// in-order pair FIFO and drives the A/B register file write ports one pair
// per cycle. Write enables are sanitised so the ports never see an x0 write
// or a same-register collision; the younger slot B wins a collision.
// The pending mask lets the issue stage stall on buffered or in-flight writes.
// Optional build macro RF_WB_STATS_EN adds the waw_squash_cnt and
// x0_drop_cnt statistics outputs.
module rf_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_a_vld,
    input  logic [4:0]      in_a_rd,
    input  logic [XLEN-1:0] in_a_wd,
    input  logic            in_b_vld,
    input  logic [4:0]      in_b_rd,
    input  logic [XLEN-1:0] in_b_wd,
    output logic            a_we,
    output logic [4:0]      a_rd,
    output logic [XLEN-1:0] a_wd,
    output logic            b_we,
    output logic [4:0]      b_rd,
    output logic [XLEN-1:0] b_wd,
    output logic [31:0]     pending
`ifdef RF_WB_STATS_EN
    ,
    output logic [31:0]     waw_squash_cnt,
    output logic [31:0]     x0_drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DEPTH-1:0] ent_valid;

    logic             mem_a_vld [DEPTH];
    logic [4:0]       mem_a_rd  [DEPTH];
    logic [XLEN-1:0]  mem_a_wd  [DEPTH];
    logic             mem_b_vld [DEPTH];
    logic [4:0]       mem_b_rd  [DEPTH];
    logic [XLEN-1:0]  mem_b_wd  [DEPTH];

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             head_a_ok;
    logic             head_b_ok;
    logic             head_waw;

    assign head  = rd_ptr[AW-1:0];
    assign tail  = wr_ptr[AW-1:0];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Readiness depends on occupancy alone so upstream never sees a loop through in_valid.
    assign in_ready = !full;

    // A flush wins over a same-cycle push and suppresses the pop of the head.
    assign push = in_valid && !full && !flush;
    assign pop  = !empty && !flush;

    // Sanitised write enables of the head pair: no x0 writes, and A yields to B on a collision.
    assign head_a_ok = mem_a_vld[head] && (mem_a_rd[head] != 5'd0);
    assign head_b_ok = mem_b_vld[head] && (mem_b_rd[head] != 5'd0);
    assign head_waw  = head_a_ok && head_b_ok && (mem_a_rd[head] == mem_b_rd[head]);

    // Pointer and occupancy bookkeeping; flush and reset both empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                rd_ptr          <= rd_ptr + PTR_ONE;
                ent_valid[head] <= 1'b0;
            end
            if (push) begin
                wr_ptr          <= wr_ptr + PTR_ONE;
                ent_valid[tail] <= 1'b1;
            end
        end
    end

    // Pair storage; contents are only meaningful where ent_valid is set, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_vld[tail] <= in_a_vld;
            mem_a_rd[tail]  <= in_a_rd;
            mem_a_wd[tail]  <= in_a_wd;
            mem_b_vld[tail] <= in_b_vld;
            mem_b_rd[tail]  <= in_b_rd;
            mem_b_wd[tail]  <= in_b_wd;
        end
    end

    // Write port registers: load the head on a pop, otherwise drop the enables and hold rd/wd.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_we <= 1'b0;
            a_rd <= 5'd0;
            a_wd <= '0;
            b_we <= 1'b0;
            b_rd <= 5'd0;
            b_wd <= '0;
        end else if (pop) begin
            a_we <= head_a_ok && !head_waw;
            a_rd <= mem_a_rd[head];
            a_wd <= mem_a_wd[head];
            b_we <= head_b_ok;
            b_rd <= mem_b_rd[head];
            b_wd <= mem_b_wd[head];
        end else begin
            a_we <= 1'b0;
            b_we <= 1'b0;
        end
    end

    // Pending mask: every register targeted by a buffered slot or an enabled write port.
    always_comb begin
        pending = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && mem_a_vld[i] && (mem_a_rd[i] != 5'd0)) begin
                pending[mem_a_rd[i]] = 1'b1;
            end
            if (ent_valid[i] && mem_b_vld[i] && (mem_b_rd[i] != 5'd0)) begin
                pending[mem_b_rd[i]] = 1'b1;
            end
        end
        if (a_we) begin
            pending[a_rd] = 1'b1;
        end
        if (b_we) begin
            pending[b_rd] = 1'b1;
        end
        pending[0] = 1'b0;
    end

`ifdef RF_WB_STATS_EN
    logic        head_a_x0;
    logic        head_b_x0;
    logic [1:0]  x0_inc;
    logic [32:0] waw_sum;
    logic [32:0] x0_sum;

    assign head_a_x0 = mem_a_vld[head] && (mem_a_rd[head] == 5'd0);
    assign head_b_x0 = mem_b_vld[head] && (mem_b_rd[head] == 5'd0);
    assign x0_inc    = {1'b0, head_a_x0} + {1'b0, head_b_x0};
    assign waw_sum   = {1'b0, waw_squash_cnt} + 33'(head_waw);
    assign x0_sum    = {1'b0, x0_drop_cnt} + 33'(x0_inc);

    // Saturating statistics counters; they survive a flush and clear only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            waw_squash_cnt <= 32'd0;
            x0_drop_cnt    <= 32'd0;
        end else if (pop) begin
            waw_squash_cnt <= waw_sum[32] ? 32'hFFFF_FFFF : waw_sum[31:0];
            x0_drop_cnt    <= x0_sum[32]  ? 32'hFFFF_FFFF : x0_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter
// Directed scenarios with literal expectations, followed by randomized traffic
// checked every cycle against a queue-based model of the pair FIFO.
// Honours RF_WB_STATS_EN when defined.
module tb_rf_writeback_arbiter;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            in_a_vld;
    logic [4:0]      in_a_rd;
    logic [XLEN-1:0] in_a_wd;
    logic            in_b_vld;
    logic [4:0]      in_b_rd;
    logic [XLEN-1:0] in_b_wd;
    logic            a_we;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_wd;
    logic            b_we;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_wd;
    logic [31:0]     pending;
`ifdef RF_WB_STATS_EN
    logic [31:0]     waw_squash_cnt;
    logic [31:0]     x0_drop_cnt;
`endif

    rf_writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a_vld(in_a_vld),
        .in_a_rd(in_a_rd),
        .in_a_wd(in_a_wd),
        .in_b_vld(in_b_vld),
        .in_b_rd(in_b_rd),
        .in_b_wd(in_b_wd),
        .a_we(a_we),
        .a_rd(a_rd),
        .a_wd(a_wd),
        .b_we(b_we),
        .b_rd(b_rd),
        .b_wd(b_wd),
        .pending(pending)
`ifdef RF_WB_STATS_EN
        ,
        .waw_squash_cnt(waw_squash_cnt),
        .x0_drop_cnt(x0_drop_cnt)
`endif
    );

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] aw;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bw;
    } pair_t;

    pair_t       q[$];
    logic        m_a_we;
    logic [4:0]  m_a_rd;
    logic [31:0] m_a_wd;
    logic        m_b_we;
    logic [4:0]  m_b_rd;
    logic [31:0] m_b_wd;
    logic [31:0] m_waw_cnt;
    logic [31:0] m_x0_cnt;

    int compared   = 0;
    int mismatched = 0;
    bit check_en   = 0;

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Advance the model by one clock edge using the inputs that were stable before the edge.
    task automatic modelStep();
        pair_t p;
        bit    can_push;
        if (rst) begin
            q.delete();
            m_a_we = 0; m_a_rd = 0; m_a_wd = 0;
            m_b_we = 0; m_b_rd = 0; m_b_wd = 0;
            m_waw_cnt = 0; m_x0_cnt = 0;
        end else if (flush) begin
            q.delete();
            m_a_we = 0;
            m_b_we = 0;
        end else begin
            can_push = (q.size() < DEPTH);
            if (q.size() > 0) begin
                p = q.pop_front();
                m_b_we = p.bv && (p.br != 0);
                m_a_we = p.av && (p.ar != 0) && !(m_b_we && p.ar == p.br);
                m_a_rd = p.ar; m_a_wd = p.aw;
                m_b_rd = p.br; m_b_wd = p.bw;
                if (p.av && p.ar != 0 && m_b_we && p.ar == p.br) m_waw_cnt = sat_inc(m_waw_cnt);
                if (p.av && p.ar == 0) m_x0_cnt = sat_inc(m_x0_cnt);
                if (p.bv && p.br == 0) m_x0_cnt = sat_inc(m_x0_cnt);
            end else begin
                m_a_we = 0;
                m_b_we = 0;
            end
            if (in_valid && can_push) begin
                p.av = in_a_vld; p.ar = in_a_rd; p.aw = in_a_wd;
                p.bv = in_b_vld; p.br = in_b_rd; p.bw = in_b_wd;
                q.push_back(p);
            end
        end
    endtask

    function automatic logic [31:0] expPending();
        logic [31:0] m;
        m = 0;
        foreach (q[i]) begin
            if (q[i].av && q[i].ar != 0) m[q[i].ar] = 1'b1;
            if (q[i].bv && q[i].br != 0) m[q[i].br] = 1'b1;
        end
        if (m_a_we) m[m_a_rd] = 1'b1;
        if (m_b_we) m[m_b_rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic checkOutput();
        check("a_we", 32'(a_we), 32'(m_a_we));
        check("b_we", 32'(b_we), 32'(m_b_we));
        check("a_rd", 32'(a_rd), 32'(m_a_rd));
        check("b_rd", 32'(b_rd), 32'(m_b_rd));
        check("a_wd", a_wd, m_a_wd);
        check("b_wd", b_wd, m_b_wd);
        check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        check("pending", pending, expPending());
        check("waw_invariant", 32'(a_we && b_we && (a_rd == b_rd)), 32'd0);
`ifdef RF_WB_STATS_EN
        check("waw_squash_cnt", waw_squash_cnt, m_waw_cnt);
        check("x0_drop_cnt", x0_drop_cnt, m_x0_cnt);
`endif
    endtask

    // Compare process: outputs are stable mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    task automatic applyStimulus(input logic v, input logic fl,
                                 input logic av, input logic [4:0] ar, input logic [31:0] aw,
                                 input logic bv, input logic [4:0] br, input logic [31:0] bw);
        in_valid = v;  flush = fl;
        in_a_vld = av; in_a_rd = ar; in_a_wd = aw;
        in_b_vld = bv; in_b_rd = br; in_b_wd = bw;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #2;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        check_en = 1;
        tick();
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_pending", pending, 32'd0);
        check("reset_a_we", 32'(a_we), 32'd0);

        // Basic pair: ports one cycle after the push edge.
        applyStimulus(1, 0, 1, 5'd5, 32'h11, 1, 5'd6, 32'h22);
        tick();
        check("basic_pending_buffered", pending, 32'h0000_0060);
        idle();
        tick();
        check("basic_a_we", 32'(a_we), 32'd1);
        check("basic_a_rd", 32'(a_rd), 32'd5);
        check("basic_a_wd", a_wd, 32'h11);
        check("basic_b_we", 32'(b_we), 32'd1);
        check("basic_b_rd", 32'(b_rd), 32'd6);
        check("basic_b_wd", b_wd, 32'h22);
        check("basic_pending_ports", pending, 32'h0000_0060);
        tick();
        check("basic_pending_after", pending, 32'd0);

        // Same destination in both slots: younger B wins.
        applyStimulus(1, 0, 1, 5'd7, 32'hAA, 1, 5'd7, 32'hBB);
        tick();
        idle();
        tick();
        check("waw_a_we", 32'(a_we), 32'd0);
        check("waw_b_we", 32'(b_we), 32'd1);
        check("waw_b_rd", 32'(b_rd), 32'd7);
        check("waw_b_wd", b_wd, 32'hBB);
`ifdef RF_WB_STATS_EN
        check("waw_cnt_literal", waw_squash_cnt, 32'd1);
`endif

        // Both slots target x0.
        applyStimulus(1, 0, 1, 5'd0, 32'h33, 1, 5'd0, 32'h44);
        tick();
        idle();
        tick();
        check("x0_a_we", 32'(a_we), 32'd0);
        check("x0_b_we", 32'(b_we), 32'd0);
        check("x0_pending", pending, 32'd0);
`ifdef RF_WB_STATS_EN
        check("x0_cnt_literal", x0_drop_cnt, 32'd2);
`endif

        // Ten back-to-back pushes stream through one per cycle in order.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 1, 5'(i + 1), 32'(i * 16 + 1), 1, 5'(i + 11), 32'(i));
            tick();
            check("burst_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) check("burst_order", 32'(a_rd), 32'(i));
        end
        idle();
        tick();
        check("burst_last", 32'(a_rd), 32'd10);

        // Flush with a simultaneous push drops both the buffered and the offered pair.
        applyStimulus(1, 0, 1, 5'd20, 32'h20, 1, 5'd21, 32'h21);
        tick();
        applyStimulus(1, 1, 1, 5'd22, 32'h22, 1, 5'd23, 32'h23);
        tick();
        check("flush_a_we", 32'(a_we), 32'd0);
        check("flush_b_we", 32'(b_we), 32'd0);
        check("flush_pending", pending, 32'd0);
        idle();
        tick();
        check("flush_no_late_a", 32'(a_we), 32'd0);
        check("flush_no_late_b", 32'(b_we), 32'd0);
        check("flush_pending_after", pending, 32'd0);

        // Reset with work in flight.
        applyStimulus(1, 0, 1, 5'd3, 32'h3, 1, 5'd4, 32'h4);
        tick();
        applyStimulus(1, 0, 1, 5'd8, 32'h8, 1, 5'd9, 32'h9);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_a_we", 32'(a_we), 32'd0);
        check("rst_a_rd", 32'(a_rd), 32'd0);
        check("rst_a_wd", a_wd, 32'd0);
        check("rst_b_we", 32'(b_we), 32'd0);
        check("rst_b_rd", 32'(b_rd), 32'd0);
        check("rst_b_wd", b_wd, 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("rst_no_late_a", 32'(a_we), 32'd0);
        check("rst_no_late_b", 32'(b_we), 32'd0);

        // Randomized traffic with occasional flush and reset, biased towards colliding registers.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] ra;
            logic [4:0] rb;
            ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                          1'($urandom), ra, $urandom, 1'($urandom), rb, $urandom);
            rst = ($urandom_range(0, 127) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();
        @(negedge clk);
        #1;
        check_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
